sobel_window_gen: RTL and testbench

Pixel-stream responder ahead of the Sobel core. It accepts 8-bit raster-order pixels and keeps two line buffers of history. For every interior pixel position it emits one 72-bit 3x3 neighbourhood window to the Sobel datapath. It also marks frame start and frame end, so the capture side can count exactly (W-2)*(H-2) results.

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/sobel_line_buffer.sv | 25 ++
 rtl/sobel_window_gen.sv | 197 +++++++++++++++++++
 tb/tb_sobel_window_gen.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, window tap layout and FSM states for the Sobel
// window generator.
package sobel_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int PIX_W_DEF = 8;
    localparam int WIN_TAPS  = 9;
    localparam int WIN_W     = WIN_TAPS * PIX_W_DEF;

    // Tap index inside the packed window; TL lands in the top bits.
    localparam int TAP_TL = 8;
    localparam int TAP_TM = 7;
    localparam int TAP_TR = 6;
    localparam int TAP_ML = 5;
    localparam int TAP_MM = 4;
    localparam int TAP_MR = 3;
    localparam int TAP_BL = 2;
    localparam int TAP_BM = 1;
    localparam int TAP_BR = 0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel history: synchronous write, combinational read,
// so a read at the address being written returns the old pixel.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 window generator for the Sobel core, fed by a raster pixel stream.
// Optional SOBEL_WIN_SOF_RESYNC_EN: pix_sof checking and frame resync.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIX_W-1:0]      pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic                  pix_ready,
    output logic [9*PIX_W-1:0]    win_out,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  win_sof,
    output logic                  win_eof,
    output logic                  frame_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e state_q, state_d;

    logic [CW-1:0] col_q, col_d, eff_col;
    logic [RW-1:0] row_q, row_d, eff_row;

    logic [WIN_TAPS-1:0][PIX_W-1:0] tap_q, tap_d;
    logic [9*PIX_W-1:0] win_q, win_d;

    logic win_valid_q, win_valid_d;
    logic win_sof_q, win_sof_d;
    logic win_eof_q, win_eof_d;
    logic frame_err_q, frame_err_d;

    logic accept, emit, last_col, last_row;
    logic resync, sof_err, done_err;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    assign accept = pix_valid && pix_ready;

`ifdef SOBEL_WIN_SOF_RESYNC_EN
    logic at_origin;
    assign at_origin = (row_q == '0) && (col_q == '0);
    assign resync    = accept && pix_sof && !at_origin;
    assign sof_err   = accept && (pix_sof != at_origin);
`else
    logic sof_unused;
    assign sof_unused = pix_sof;
    assign resync     = 1'b0;
    assign sof_err    = 1'b0;
`endif

    // A resynced pixel is placed at (0,0) for addressing and counting.
    assign eff_col  = resync ? '0 : col_q;
    assign eff_row  = resync ? '0 : row_q;
    assign last_col = (eff_col == CW'(IMG_W - 1));
    assign last_row = (eff_row == RW'(IMG_H - 1));
    assign emit     = accept && (eff_row >= RW'(2))
                             && (eff_col >= CW'(2));

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (eff_col),
        .wdata_i (pix_in),
        .rdata_o (lb1_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (eff_col),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = FILL;
            FILL: begin
                if (accept && (eff_row == RW'(2))
                           && (eff_col == CW'(1))) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (resync) begin
                    state_d = FILL;
                end else if (accept && last_row && last_col) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (win_valid_q && win_ready) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    always_comb begin
        pix_ready = ((state_q == FILL) || (state_q == STREAM))
                    && (!win_valid_q || win_ready);
        done_err  = (state_q == DONE) && pix_valid;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end
        end
    end

    // Window columns slide left; the new right column comes from history.
    always_comb begin
        tap_d = tap_q;
        if (accept) begin
            tap_d[TAP_TL] = tap_q[TAP_TM];
            tap_d[TAP_TM] = tap_q[TAP_TR];
            tap_d[TAP_TR] = lb2_rd;
            tap_d[TAP_ML] = tap_q[TAP_MM];
            tap_d[TAP_MM] = tap_q[TAP_MR];
            tap_d[TAP_MR] = lb1_rd;
            tap_d[TAP_BL] = tap_q[TAP_BM];
            tap_d[TAP_BM] = tap_q[TAP_BR];
            tap_d[TAP_BR] = pix_in;
        end
    end

    always_comb begin
        win_d       = win_q;
        win_valid_d = win_valid_q;
        win_sof_d   = win_sof_q;
        win_eof_d   = win_eof_q;
        if (emit) begin
            win_d       = tap_d;
            win_valid_d = 1'b1;
            win_sof_d   = (eff_row == RW'(2)) && (eff_col == CW'(2));
            win_eof_d   = last_row && last_col;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
            win_sof_d   = 1'b0;
            win_eof_d   = 1'b0;
        end
        frame_err_d = frame_err_q || done_err || sof_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            tap_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eof_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            tap_q       <= tap_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_sof_q   <= win_sof_d;
            win_eof_q   <= win_eof_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign win_out   = win_q;
    assign win_valid = win_valid_q;
    assign win_sof   = win_sof_q;
    assign win_eof   = win_eof_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 image: a golden 3x3
// extraction queues expected windows as pixels are accepted.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;

`ifdef SOBEL_WIN_SOF_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [71:0] win_out;
    logic        win_valid;
    logic        win_ready;
    logic        win_sof;
    logic        win_eof;
    logic        frame_err;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_sof   (win_sof),
        .win_eof   (win_eof),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [71:0] win;
    } wrec_t;

    int n_cmp = 0;
    int n_bad = 0;

    wrec_t      exp_q[$];
    wrec_t      got_q[$];
    logic [7:0] src_pix[$];
    bit         src_sof[$];
    logic [7:0] img [H][W];
    int mrow, mcol, n_acc, stall_viol;

    function automatic logic [71:0] win_at(int t);
        logic [71:0] w;
        w = {8'(t), 8'(t + 1), 8'(t + 2),
             8'(t + W), 8'(t + W + 1), 8'(t + W + 2),
             8'(t + 2 * W), 8'(t + 2 * W + 1), 8'(t + 2 * W + 2)};
        return w;
    endfunction

    task automatic model_accept(input logic [7:0] v, input bit s);
        wrec_t e;
        if (RESYNC && s && !(mrow == 0 && mcol == 0)) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = v;
        if (mrow >= 2 && mcol >= 2) begin
            e.sof = (mrow == 2 && mcol == 2);
            e.eof = (mrow == H - 1 && mcol == W - 1);
            e.win = {img[mrow-2][mcol-2], img[mrow-2][mcol-1],
                     img[mrow-2][mcol], img[mrow-1][mcol-2],
                     img[mrow-1][mcol-1], img[mrow-1][mcol],
                     img[mrow][mcol-2], img[mrow][mcol-1],
                     img[mrow][mcol]};
            exp_q.push_back(e);
        end
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            src_pix.push_back(8'(base + i));
            src_sof.push_back((i % (W * H)) == 0);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = '0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mrow = 0;
        mcol = 0;
        n_acc = 0;
        stall_viol = 0;
        exp_q.delete();
        got_q.delete();
        src_pix.delete();
        src_sof.delete();
    endtask

    // mode 0: win_ready high; mode 1: win_ready toggles every cycle.
    task automatic run(input int mode, input int stop_after,
                       output bit timed_out);
        int cyc;
        int idle;
        bit tog;
        wrec_t g;
        cyc = 0;
        idle = 0;
        tog = 1'b0;
        timed_out = 1'b0;
        while (idle < 6) begin
            pix_valid = (src_pix.size() > 0)
                        && (stop_after < 0 || n_acc < stop_after);
            pix_in  = (src_pix.size() > 0) ? src_pix[0] : 8'h00;
            pix_sof = (src_pix.size() > 0) ? src_sof[0] : 1'b0;
            win_ready = (mode == 0) ? 1'b1 : tog;
            tog = ~tog;
            @(negedge clk);
            if (win_valid && !win_ready && pix_ready) stall_viol++;
            if (pix_valid && pix_ready) begin
                model_accept(src_pix[0], src_sof[0]);
                void'(src_pix.pop_front());
                void'(src_sof.pop_front());
                n_acc++;
            end
            if (win_valid && win_ready) begin
                g.sof = win_sof;
                g.eof = win_eof;
                g.win = win_out;
                got_q.push_back(g);
            end
            @(posedge clk);
            #1;
            if (!pix_valid && !win_valid) idle++;
            else idle = 0;
            cyc++;
            if (cyc > 2000) begin
                timed_out = 1'b1;
                break;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = '0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({pix_ready, win_valid, win_sof, win_eof, frame_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=00000",
                     {pix_ready, win_valid, win_sof, win_eof, frame_err});
        end
        n_cmp++;
        if (win_out !== 72'h0) begin
            n_bad++;
            $display("FAIL reset_win_out got=%h want=0", win_out);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pix_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_pix_ready got=%b want=0", pix_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_pix_ready got=%b want=1", pix_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream(input int mode);
        bit to;
        wrec_t g, e;
        int nsof, neof, n;
        do_reset();
        load(0, W * H);
        run(mode, -1, to);
        n_cmp++;
        if (to !== 1'b0) begin
            n_bad++;
            $display("FAIL stream%0d_timeout got=%b want=0", mode, to);
        end
        n_cmp++;
        if (got_q.size() !== 6) begin
            n_bad++;
            $display("FAIL stream%0d_count got=%0d want=6", mode, got_q.size());
        end
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== {1'b1, 1'b0, win_at(0)}) begin
            n_bad++;
            $display("FAIL stream%0d_first got=%h want=%h", mode, got_q[0],
                     {1'b1, 1'b0, win_at(0)});
        end
        n_cmp++;
        if (got_q.size() > 5 && got_q[5] !== {1'b0, 1'b1, win_at(7)}) begin
            n_bad++;
            $display("FAIL stream%0d_last got=%h want=%h", mode, got_q[5],
                     {1'b0, 1'b1, win_at(7)});
        end
        nsof = 0;
        neof = 0;
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            nsof += int'(g.sof);
            neof += int'(g.eof);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL stream%0d_win%0d got=%h want=%h", mode, n, g, e);
            end
            n++;
        end
        n_cmp++;
        if (nsof !== 1 || neof !== 1) begin
            n_bad++;
            $display("FAIL stream%0d_flags got sof=%0d eof=%0d want 1/1",
                     mode, nsof, neof);
        end
        n_cmp++;
        if (stall_viol !== 0) begin
            n_bad++;
            $display("FAIL stream%0d_stall got=%0d want=0", mode, stall_viol);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL stream%0d_frame_err got=%b want=0", mode, frame_err);
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        wrec_t g, e;
        int n;
        do_reset();
        load(0, W * H);
        run(0, 10, to);
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre_ready got=%b want=1", pix_ready);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({pix_ready, win_valid, win_sof, win_eof} !== 4'b0) begin
            n_bad++;
            $display("FAIL mid_reset_flags got=%b want=0000",
                     {pix_ready, win_valid, win_sof, win_eof});
        end
        do_reset();
        load(0, W * H);
        run(0, -1, to);
        n_cmp++;
        if (to !== 1'b0 || got_q.size() !== 6) begin
            n_bad++;
            $display("FAIL mid_count got=%0d want=6 (timeout=%b)",
                     got_q.size(), to);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL mid_win%0d got=%h want=%h", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        wrec_t g, e;
        int n;
        do_reset();
        load(0, 2 * W * H);
        run(0, -1, to);
        n_cmp++;
        if (to !== 1'b0 || got_q.size() !== 12) begin
            n_bad++;
            $display("FAIL b2b_count got=%0d want=12 (timeout=%b)",
                     got_q.size(), to);
        end
        n_cmp++;
        if (got_q.size() > 6 && got_q[6] !== {1'b1, 1'b0, win_at(20)}) begin
            n_bad++;
            $display("FAIL b2b_second_first got=%h want=%h", got_q[6],
                     {1'b1, 1'b0, win_at(20)});
        end
        // The source keeps pix_valid high through DONE, which is flagged.
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_frame_err got=%b want=1", frame_err);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_win%0d got=%h want=%h", n, g, e);
            end
            n++;
        end
    endtask

`ifdef SOBEL_WIN_SOF_RESYNC_EN
    task automatic test_resync();
        bit to;
        wrec_t g, e;
        int n;
        do_reset();
        load(0, 7);
        load(0, W * H);
        run(0, -1, to);
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL resync_frame_err got=%b want=1", frame_err);
        end
        n_cmp++;
        if (to !== 1'b0 || got_q.size() !== 6) begin
            n_bad++;
            $display("FAIL resync_count got=%0d want=6 (timeout=%b)",
                     got_q.size(), to);
        end
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== {1'b1, 1'b0, win_at(0)}) begin
            n_bad++;
            $display("FAIL resync_first got=%h want=%h", got_q[0],
                     {1'b1, 1'b0, win_at(0)});
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL resync_win%0d got=%h want=%h", n, g, e);
            end
            n++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream(0);
        test_stream(1);
        test_reset_midframe();
        test_back_to_back();
`ifdef SOBEL_WIN_SOF_RESYNC_EN
        test_resync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
